ct_ifu_ind_btb_ctrl: RTL and testbench
======================================

# ct_ifu_ind_btb_ctrl

Access controller for the 256x23 indirect-branch BTB SRAM array in the IFU. It shares the single-port array between three users: IFU prediction reads, BJU update writes held in a one-entry write buffer, and a hardware invalidation sweep after reset or on CP0 request. It drives the array's chip-enable, write-enable, index, data and clock-enable pins from flops and returns read data with a fixed latency.

## Interface
- No parameters; depth 256 (8-bit index), width 23 fixed.
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  reset; asynchronous, active-low
- cp0_ifu_ind_btb_en  in  1  predictor enable; low blocks reads
- cp0_ifu_ind_btb_inv  in  1  invalidate-all request, single-cycle pulse
- ifu_ind_btb_rd_req  in  1  read request
- ifu_ind_btb_rd_index  in  8  read index
- ctrl_ind_btb_rd_grant  out  1  read accepted this cycle (combinational)
- ctrl_ind_btb_rd_vld  out  1  read data valid, 2 cycles after grant
- ctrl_ind_btb_rd_data  out  23  read data, qualified by rd_vld
- bju_ind_btb_wr_req  in  1  update request
- bju_ind_btb_wr_index  in  8  update index
- bju_ind_btb_wr_data  in  23  update data
- ctrl_ind_btb_wr_ack  out  1  update taken this cycle (combinational)
- ctrl_ind_btb_inv_busy  out  1  sweep in progress
- ind_btb_cen_b / ind_btb_wen_b  out  1  array enable / write enable, both active-low
- ind_btb_index  out  8  array index
- ind_btb_data_in  out  23  array write data
- ind_btb_clk_en  out  1  array clock-gate enable
- ind_btb_dout  in  23  array read data

## Operation
- FSM states: INIT, IDLE. Reset state is INIT with the sweep counter at 0.
- INIT sweep:
  - One array write per cycle: index = counter, data = 0.
  - Takes 256 cycles; after index 255 the FSM goes to IDLE.
  - inv_busy = 1 throughout INIT.
- A cp0 inv pulse in IDLE enters INIT with the counter at 0. A pulse during INIT restarts the counter at 0.
- The write buffer (one entry: vld, index, data) is cleared on INIT entry.
- Requests during INIT:
  - wr_ack = 1, but the update is discarded.
  - rd_grant = 0.
- IDLE arbitration, one array access per cycle:
  - Read wins when rd_req = 1, en = 1, and the buffer is not starved.
  - Otherwise a valid buffer entry drains as a write.
  - With no access, the array pins idle: cen_b = 1, wen_b = 1, clk_en = 0.
- Starvation: a 2-bit counter counts consecutive cycles in which a valid buffer entry lost to a read.
  - When the counter reaches 3, the next cycle forces the write and rd_grant = 0.
  - The counter clears whenever the buffer drains.
- wr_ack = !buf_vld OR (buffer drains this cycle). On ack in IDLE the buffer loads the BJU index and data.
  - If buffer and BJU request are both pending and the buffer does not drain, wr_ack = 0 and the BJU holds its request.
- en = 0: rd_grant = 0; writes are still accepted and drained.

## Timing
- Array pins are registered. A decision in cycle T appears on the pins in T+1. ind_btb_dout is valid in T+2.
- Read: grant in T, rd_vld = 1 in T+2, rd_data = ind_btb_dout, or the bypass value (see Configuration).
- Write: ack in T loads the buffer in T+1. The earliest array write is on the pins in T+2.
- Back-to-back reads are granted every cycle subject to starvation. Throughput is 1 access per cycle.
- Reset values:
  - ind_btb_cen_b = 1, ind_btb_wen_b = 1.
  - ind_btb_index = 0, ind_btb_data_in = 0, ind_btb_clk_en = 0.
  - rd_vld = 0, rd_data = 0, inv_busy = 1.
- A reset asserted mid-sweep or mid-read kills the in-flight rd_vld. The sweep restarts from 0 after release.
- A read granted in the last IDLE cycle before an inv pulse still returns rd_vld 2 cycles later.

## Configuration
- CT_IFU_IND_BTB_BYPASS_EN defined:
  - A granted read whose index equals a valid buffer index does not read the array.
  - The buffer drains as a write in the same cycle.
  - rd_data in T+2 = the buffered data.
- Not defined: the array is read normally and may return pre-update data.

## Test plan
- Reset release -> inv_busy high for exactly 256 cycles; indices 0..255 each written with 0; then IDLE with pins idle.
- After init, read index 0x12 granted in T -> rd_vld in T+2 with rd_data = 0.
- Write 0x12 = 0x5A5A5 with no reads -> ack, array write in T+2. A later read of 0x12 returns 0x5A5A5.
- Continuous rd_req with buffer valid -> 3 reads granted, 4th cycle rd_grant = 0 and the write is forced. The second BJU request is held (wr_ack = 0) until the drain.
- With CT_IFU_IND_BTB_BYPASS_EN: buffer holds 0x40 = 0x11111 and a read of 0x40 is granted -> no array read; write issued; rd_data = 0x11111 at T+2. Without the macro: rd_data = old array value.
- Inv pulse at sweep index 100 -> counter restarts at 0, buffer cleared. Another inv pulse in IDLE with buffer valid -> buffer dropped, 256 zero writes.

Source files
------------

// File: rtl/ct_ifu_ind_btb_ctrl.sv
// Access controller for the 256x23 indirect-branch BTB array: prediction reads,
// buffered BJU update writes and a zeroing sweep. Optional macro: CT_IFU_IND_BTB_BYPASS_EN.
module ct_ifu_ind_btb_ctrl (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        cp0_ifu_ind_btb_en,
    input  logic        cp0_ifu_ind_btb_inv,
    input  logic        ifu_ind_btb_rd_req,
    input  logic [7:0]  ifu_ind_btb_rd_index,
    output logic        ctrl_ind_btb_rd_grant,
    output logic        ctrl_ind_btb_rd_vld,
    output logic [22:0] ctrl_ind_btb_rd_data,
    input  logic        bju_ind_btb_wr_req,
    input  logic [7:0]  bju_ind_btb_wr_index,
    input  logic [22:0] bju_ind_btb_wr_data,
    output logic        ctrl_ind_btb_wr_ack,
    output logic        ctrl_ind_btb_inv_busy,
    output logic        ind_btb_cen_b,
    output logic        ind_btb_wen_b,
    output logic [7:0]  ind_btb_index,
    output logic [22:0] ind_btb_data_in,
    output logic        ind_btb_clk_en,
    input  logic [22:0] ind_btb_dout
);

    typedef enum logic {INIT, IDLE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic        r_buf_vld;
    logic [7:0]  r_buf_idx;
    logic [22:0] r_buf_data;
    logic [1:0]  r_starve;

    logic        r_cen_b;
    logic        r_wen_b;
    logic        r_clk_en;
    logic [7:0]  r_idx;
    logic [22:0] r_din;
    logic        r_rd_p1;
    logic        r_rd_p2;

    logic        w_grant;
    logic        w_byp;
    logic        w_drain;
    logic        w_ack;
    logic        w_acc;
    logic        w_wr;
    logic [7:0]  w_idx;
    logic [22:0] w_din;

    // State register
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT: if (!cp0_ifu_ind_btb_inv && (r_cnt == 8'hFF)) w_state_nxt = IDLE;
            IDLE: if (cp0_ifu_ind_btb_inv) w_state_nxt = INIT;
            default: w_state_nxt = INIT;
        endcase
    end

    // Output / arbitration logic
    always_comb begin
        w_grant = 1'b0;
        w_byp   = 1'b0;
        w_drain = 1'b0;
        w_ack   = 1'b1;
        w_acc   = 1'b0;
        w_wr    = 1'b0;
        w_idx   = '0;
        w_din   = '0;
        if (r_state == INIT) begin
            w_acc = 1'b1;
            w_wr  = 1'b1;
            w_idx = r_cnt;
        end else begin
            w_grant = ifu_ind_btb_rd_req && cp0_ifu_ind_btb_en && (r_starve != 2'd3);
`ifdef CT_IFU_IND_BTB_BYPASS_EN
            w_byp = w_grant && r_buf_vld && (r_buf_idx == ifu_ind_btb_rd_index);
`endif
            // A bypassed read frees the port, so the buffer drains alongside it
            w_drain = r_buf_vld && (!w_grant || w_byp);
            w_ack   = !r_buf_vld || w_drain;
            if (w_drain) begin
                w_acc = 1'b1;
                w_wr  = 1'b1;
                w_idx = r_buf_idx;
                w_din = r_buf_data;
            end else if (w_grant) begin
                w_acc = 1'b1;
                w_idx = ifu_ind_btb_rd_index;
            end
        end
    end

    // Sweep counter, write buffer and starvation counter
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_cnt      <= '0;
            r_buf_vld  <= 1'b0;
            r_buf_idx  <= '0;
            r_buf_data <= '0;
            r_starve   <= '0;
        end else begin
            if (cp0_ifu_ind_btb_inv) begin
                r_cnt <= '0;
            end else if (r_state == INIT) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (cp0_ifu_ind_btb_inv || (r_state == INIT)) begin
                r_buf_vld <= 1'b0;
            end else if (w_ack && bju_ind_btb_wr_req) begin
                r_buf_vld  <= 1'b1;
                r_buf_idx  <= bju_ind_btb_wr_index;
                r_buf_data <= bju_ind_btb_wr_data;
            end else if (w_drain) begin
                r_buf_vld <= 1'b0;
            end
            if (cp0_ifu_ind_btb_inv || (r_state == INIT) || w_drain) begin
                r_starve <= '0;
            end else if (r_buf_vld && w_grant) begin
                r_starve <= r_starve + 2'd1;
            end
        end
    end

    // Registered array pins and read-return pipeline
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_cen_b  <= 1'b1;
            r_wen_b  <= 1'b1;
            r_clk_en <= 1'b0;
            r_idx    <= '0;
            r_din    <= '0;
            r_rd_p1  <= 1'b0;
            r_rd_p2  <= 1'b0;
        end else begin
            r_rd_p1 <= w_grant;
            r_rd_p2 <= r_rd_p1;
            if (w_acc) begin
                r_cen_b  <= 1'b0;
                r_wen_b  <= !w_wr;
                r_clk_en <= 1'b1;
                r_idx    <= w_idx;
                r_din    <= w_din;
            end else begin
                r_cen_b  <= 1'b1;
                r_wen_b  <= 1'b1;
                r_clk_en <= 1'b0;
            end
        end
    end

`ifdef CT_IFU_IND_BTB_BYPASS_EN
    logic        r_byp_p1;
    logic        r_byp_p2;
    logic [22:0] r_byp_d1;
    logic [22:0] r_byp_d2;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_byp_p1 <= 1'b0;
            r_byp_p2 <= 1'b0;
            r_byp_d1 <= '0;
            r_byp_d2 <= '0;
        end else begin
            r_byp_p1 <= w_byp;
            r_byp_p2 <= r_byp_p1;
            r_byp_d1 <= r_buf_data;
            r_byp_d2 <= r_byp_d1;
        end
    end

    assign ctrl_ind_btb_rd_data = !r_rd_p2 ? '0 : (r_byp_p2 ? r_byp_d2 : ind_btb_dout);
`else
    assign ctrl_ind_btb_rd_data = r_rd_p2 ? ind_btb_dout : '0;
`endif

    assign ctrl_ind_btb_rd_grant = w_grant;
    assign ctrl_ind_btb_rd_vld   = r_rd_p2;
    assign ctrl_ind_btb_wr_ack   = w_ack;
    assign ctrl_ind_btb_inv_busy = (r_state == INIT);
    assign ind_btb_cen_b         = r_cen_b;
    assign ind_btb_wen_b         = r_wen_b;
    assign ind_btb_index         = r_idx;
    assign ind_btb_data_in       = r_din;
    assign ind_btb_clk_en        = r_clk_en;

endmodule

// File: tb/tb_ct_ifu_ind_btb_ctrl.sv
// Self-checking bench for ct_ifu_ind_btb_ctrl: transaction-level model plus directed
// vectors; honours CT_IFU_IND_BTB_BYPASS_EN when defined.
module tb_ct_ifu_ind_btb_ctrl;

`ifdef CT_IFU_IND_BTB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        inv;
    logic        rd_req;
    logic [7:0]  rd_index;
    logic        grant;
    logic        rd_vld;
    logic [22:0] rd_data;
    logic        wr_req;
    logic [7:0]  wr_index;
    logic [22:0] wr_data;
    logic        ack;
    logic        busy;
    logic        cen_b;
    logic        wen_b;
    logic [7:0]  idx;
    logic [22:0] din;
    logic        clk_en;
    logic [22:0] dout;

    int total = 0;
    int bad   = 0;

    ct_ifu_ind_btb_ctrl dut (
        .forever_cpuclk        (clk),
        .cpurst_b              (rst_n),
        .cp0_ifu_ind_btb_en    (en),
        .cp0_ifu_ind_btb_inv   (inv),
        .ifu_ind_btb_rd_req    (rd_req),
        .ifu_ind_btb_rd_index  (rd_index),
        .ctrl_ind_btb_rd_grant (grant),
        .ctrl_ind_btb_rd_vld   (rd_vld),
        .ctrl_ind_btb_rd_data  (rd_data),
        .bju_ind_btb_wr_req    (wr_req),
        .bju_ind_btb_wr_index  (wr_index),
        .bju_ind_btb_wr_data   (wr_data),
        .ctrl_ind_btb_wr_ack   (ack),
        .ctrl_ind_btb_inv_busy (busy),
        .ind_btb_cen_b         (cen_b),
        .ind_btb_wen_b         (wen_b),
        .ind_btb_index         (idx),
        .ind_btb_data_in       (din),
        .ind_btb_clk_en        (clk_en),
        .ind_btb_dout          (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port array with one-cycle registered read
    logic [22:0] mem [256];
    always @(posedge clk) begin
        if (!cen_b && clk_en) begin
            if (!wen_b) mem[idx] <= din;
            else        dout <= mem[idx];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: expected contents, pending returns, buffer and sweep progress
    typedef struct {
        int          due;
        logic [22:0] d;
    } ret_t;

    ret_t        rq[$];
    logic [22:0] ref_mem [256];
    int          cyc;
    int          init_left;
    int          starve;
    bit          bvld;
    logic [7:0]  bidx;
    logic [22:0] bdata;
    int          ep_act;      // 0 none, 1 read, 2 write on the pins this cycle
    logic [7:0]  ep_idx;
    logic [22:0] ep_dat;

    initial begin
        bit eg, ea, ebyp, edr, exp_vld;
        int k;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                init_left = 256;
                starve    = 0;
                bvld      = 1'b0;
                ep_act    = 0;
                rq.delete();
                chk("rst_cen_b", cen_b, 1);
                chk("rst_wen_b", wen_b, 1);
                chk("rst_clk_en", clk_en, 0);
                chk("rst_index", idx, 0);
                chk("rst_din", din, 0);
                chk("rst_rd_vld", rd_vld, 0);
                chk("rst_rd_data", rd_data, 0);
                chk("rst_busy", busy, 1);
            end else begin
                cyc++;
                chk("cen_b", cen_b, ep_act == 0);
                chk("wen_b", wen_b, ep_act != 2);
                chk("clk_en", clk_en, ep_act != 0);
                if (ep_act != 0) chk("index", idx, ep_idx);
                if (ep_act == 2) chk("data_in", din, ep_dat);
                exp_vld = (rq.size() > 0) && (rq[0].due == cyc);
                chk("rd_vld", rd_vld, exp_vld);
                if (exp_vld) begin
                    chk("rd_data", rd_data, rq[0].d);
                    void'(rq.pop_front());
                end
                chk("inv_busy", busy, init_left > 0);

                if (init_left > 0) begin
                    eg = 1'b0;
                    ea = 1'b1;
                    k = 256 - init_left;
                    ep_act = 2;
                    ep_idx = k[7:0];
                    ep_dat = '0;
                    ref_mem[k] = '0;
                    init_left--;
                end else begin
                    eg   = rd_req && en && (starve < 3);
                    ebyp = BYP && eg && bvld && (bidx == rd_index);
                    edr  = bvld && (!eg || ebyp);
                    ea   = !bvld || edr;
                    ep_act = 0;
                    if (eg) rq.push_back('{cyc + 2, ebyp ? bdata : ref_mem[rd_index]});
                    if (edr) begin
                        ep_act = 2;
                        ep_idx = bidx;
                        ep_dat = bdata;
                        ref_mem[bidx] = bdata;
                    end else if (eg) begin
                        ep_act = 1;
                        ep_idx = rd_index;
                    end
                    if (edr) starve = 0;
                    else if (bvld && eg) starve++;
                    if (edr) bvld = 1'b0;
                    if (ea && wr_req) begin
                        bvld  = 1'b1;
                        bidx  = wr_index;
                        bdata = wr_data;
                    end
                end
                if (inv) begin
                    init_left = 256;
                    bvld      = 1'b0;
                    starve    = 0;
                end
                chk("rd_grant", grant, eg);
                chk("wr_ack", ack, ea);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] i, input logic [22:0] exp, input string nm);
        int n;
        rd_req = 1'b1;
        rd_index = i;
        @(negedge clk);
        chk({nm, "_grant"}, grant, 1);
        @(posedge clk);
        #1 rd_req = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n++;
            if (rd_vld) break;
        end
        chk({nm, "_latency"}, n, 2);
        chk({nm, "_data"}, rd_data, exp);
        tick(1);
    endtask

    task automatic wr(input logic [7:0] i, input logic [22:0] d, input string nm);
        wr_req = 1'b1;
        wr_index = i;
        wr_data = d;
        @(negedge clk);
        chk({nm, "_ack"}, ack, 1);
        @(posedge clk);
        #1 wr_req = 1'b0;
    endtask

    task automatic wait_init(input string nm);
        int n;
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk({nm, "_busy_cycles"}, n, 256);
        tick(1);
    endtask

    initial begin
        bit g[4];
        bit a[4];
        int ng;
        rst_n = 1'b0; en = 1'b1; inv = 1'b0;
        rd_req = 1'b0; rd_index = '0;
        wr_req = 1'b0; wr_index = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init("init");

        tick(2);
        rd(8'h12, 23'h0, "rd12_init");

        wr(8'h12, 23'h5A5A5, "wr12");
        @(negedge clk);
        @(negedge clk);
        chk("wr12_wen_b", wen_b, 0);
        chk("wr12_index", idx, 8'h12);
        chk("wr12_din", din, 23'h5A5A5);
        tick(1);
        rd(8'h12, 23'h5A5A5, "rd12_upd");

        // Starvation: buffer valid under continuous reads, second update held
        wr(8'h20, 23'h01234, "wr20");
        rd_req = 1'b1; rd_index = 8'h30;
        wr_req = 1'b1; wr_index = 8'h21; wr_data = 23'h00777;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g[i] = grant;
            a[i] = ack;
            @(posedge clk);
            #1;
            if (a[i]) wr_req = 1'b0;
        end
        rd_req = 1'b0;
        ng = 0;
        for (int i = 0; i < 4; i++) ng += int'(g[i]);
        chk("starve_grants", ng, 3);
        chk("starve_4th_grant", g[3], 0);
        chk("starve_held_ack", {a[0], a[1], a[2]}, 3'b000);
        chk("starve_drain_ack", a[3], 1);
        tick(3);
        rd(8'h20, 23'h01234, "rd20");
        rd(8'h21, 23'h00777, "rd21");

        // Read hitting the buffered index
        wr(8'h40, 23'h11111, "wr40");
        rd(8'h40, BYP ? 23'h11111 : 23'h0, "rd40_hit");
        tick(2);
        rd(8'h40, 23'h11111, "rd40_after");

        // Predictor disabled: reads refused, updates still taken
        en = 1'b0; rd_req = 1'b1; rd_index = 8'h12;
        wr_req = 1'b1; wr_index = 8'h60; wr_data = 23'h2BCDE;
        @(negedge clk);
        chk("dis_grant", grant, 0);
        chk("dis_ack", ack, 1);
        @(posedge clk);
        #1 rd_req = 1'b0; wr_req = 1'b0; en = 1'b1;
        tick(3);
        rd(8'h60, 23'h2BCDE, "rd60");

        // Invalidate from IDLE, then restart at sweep index 100
        tick(2);
        inv = 1'b1;
        @(posedge clk);
        #1 inv = 1'b0;
        repeat (100) @(posedge clk);
        #1 inv = 1'b1;
        @(negedge clk);
        chk("sweep_idx_99", idx, 8'd99);
        chk("sweep_busy", busy, 1);
        @(posedge clk);
        #1 inv = 1'b0;
        wait_init("inv_restart");

        // Invalidate with a buffered update that loses to a read: update dropped
        tick(2);
        wr(8'h50, 23'h3AAAA, "wr50");
        rd_req = 1'b1; rd_index = 8'h50; inv = 1'b1;
        @(negedge clk);
        chk("inv_rd_grant", grant, 1);
        @(posedge clk);
        #1 rd_req = 1'b0; inv = 1'b0;
        wait_init("inv_buf");
        tick(2);
        rd(8'h50, 23'h0, "rd50_dropped");
        rd(8'h12, 23'h0, "rd12_swept");

        // Reset mid-read and mid-sweep
        rd_req = 1'b1; rd_index = 8'h60;
        @(negedge clk);
        @(posedge clk);
        #1 rd_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("killed_rd_vld", rd_vld, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(50);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init("reinit");
        tick(2);
        rd(8'h60, 23'h0, "rd60_reset");

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
